// File: rtl/sm_step_pkg.sv
// Shared types for the single-step clock controller.
// State encoding, counter widths and a width helper.
package sm_step_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } state_e;

  localparam int unsigned STEP_CNT_W = 16;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sm_step_debounce.sv
// 2-flop synchronizer plus stability counter for one raw input.
// rel_ok flags a real synchronized sample that reads 1.
module sm_debounce
  import sm_step_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter logic        RST_VAL         = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic fall,
  output logic rel_ok
);

  localparam int unsigned CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [1:0]    vld_q;
  logic          level_q, level_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // A bounce back to the accepted level clears the count.
  always_comb begin
    level_d = level_q;
    fall_d  = 1'b0;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync_q[1];
        fall_d  = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= {2{RST_VAL}};
      vld_q   <= 2'b00;
      level_q <= RST_VAL;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], din};
      vld_q   <= {vld_q[0], 1'b1};
      level_q <= level_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level  = level_q;
  assign fall   = fall_q;
  assign rel_ok = vld_q[1] & sync_q[1];

endmodule

// File: rtl/sm_step_ctrl.sv
// Single-step / free-run clock-enable controller for sm_top.
// Define SM_STEP_AUTOREPEAT_EN for auto-repeat while the key is held.
module sm_step_ctrl
  import sm_step_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned STEP_CYCLES     = 16,
  parameter int unsigned REPEAT_CYCLES   = 25000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stepKey_n,
  input  logic                  runSw,
  output logic                  clkEnable,
  output logic [STEP_CNT_W-1:0] stepCount,
  output logic                  busy
);

  localparam int unsigned PW = cnt_w(STEP_CYCLES);
  localparam logic [PW-1:0] PCNT_MAX = PW'(STEP_CYCLES - 1);

  logic key_lvl, key_fall, key_ok;
  logic run_lvl, run_fall, run_ok;

  sm_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RST_VAL        (1'b1)
  ) u_key_db (
    .clk   (clk),
    .rst   (rst),
    .din   (stepKey_n),
    .level (key_lvl),
    .fall  (key_fall),
    .rel_ok(key_ok)
  );

  sm_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RST_VAL        (1'b0)
  ) u_run_db (
    .clk   (clk),
    .rst   (rst),
    .din   (runSw),
    .level (run_lvl),
    .fall  (run_fall),
    .rel_ok(run_ok)
  );

  state_e                state_q, state_d;
  logic                  en_q, en_d;
  logic [PW-1:0]         pcnt_q, pcnt_d;
  logic [STEP_CNT_W-1:0] cnt_q, cnt_d;
  logic                  armed_q, armed_d;
  logic                  unused_ok;

`ifdef SM_STEP_AUTOREPEAT_EN
  localparam int unsigned RW = cnt_w(REPEAT_CYCLES);
  localparam logic [RW-1:0] RPT_MAX = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rpt_q, rpt_d;

  // Period runs from the start of each pulse.
  always_comb begin
    rpt_d = '0;
    if (state_q == STEP || state_q == HOLD)
      rpt_d = rpt_q + 1'b1;
    if (state_d == STEP && state_q != STEP)
      rpt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rpt_q <= '0;
    else     rpt_q <= rpt_d;
  end

  assign unused_ok = &{1'b0, run_fall, run_ok};
`else
  assign unused_ok = &{1'b0, run_fall, run_ok,
                       REPEAT_CYCLES != 0};
`endif

  // A key held through reset never armed the step path.
  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    pcnt_d  = pcnt_q;
    cnt_d   = cnt_q;
    armed_d = armed_q | key_ok;
    unique case (state_q)
      IDLE: begin
        if (run_lvl) begin
          state_d = RUN;
          en_d    = 1'b1;
        end else if (key_fall && armed_q) begin
          state_d = STEP;
          en_d    = 1'b1;
          pcnt_d  = '0;
        end
      end
      STEP: begin
        if (pcnt_q == PCNT_MAX) begin
          cnt_d   = cnt_q + 1'b1;
          pcnt_d  = '0;
          en_d    = run_lvl;
          state_d = run_lvl ? RUN : HOLD;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (run_lvl) begin
          state_d = RUN;
          en_d    = 1'b1;
        end else if (key_lvl) begin
          state_d = IDLE;
        end
`ifdef SM_STEP_AUTOREPEAT_EN
        else if (rpt_q == RPT_MAX) begin
          state_d = STEP;
          en_d    = 1'b1;
          pcnt_d  = '0;
        end
`endif
      end
      RUN: begin
        if (!run_lvl) begin
          en_d    = 1'b0;
          state_d = key_lvl ? IDLE : HOLD;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      pcnt_q  <= '0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      pcnt_q  <= pcnt_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  assign clkEnable = en_q;
  assign stepCount = cnt_q;
  assign busy      = (state_q == STEP);

endmodule
